// File: rtl/rx_deframer_if.sv
// Bus bundle for rx_deframer: serial line, tick and control in, frame fields and status out.
interface rx_deframer_if;
  logic       baud_tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic [7:0] raw_data;
  logic       parity_bit;
  logic       start_bit;
  logic       stop_bit;
  logic       recieved_flag;
  logic       busy;

  modport master (
    output baud_tick, rx_in, parity_type,
    input  raw_data, parity_bit, start_bit, stop_bit, recieved_flag, busy
  );

  modport slave (
    input  baud_tick, rx_in, parity_type,
    output raw_data, parity_bit, start_bit, stop_bit, recieved_flag, busy
  );
endinterface

// File: rtl/rx_deframer.sv
// UART receive deframer: synchronizes rx_in, walks start/data/parity/stop bits on
// oversampled ticks and publishes the raw frame fields with a one-clk flag.
module rx_deframer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic         clk,
  input logic         reset_n,
  rx_deframer_if.slave bus
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfM1   = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

  state_e          r_state;
  logic            r_sync1, r_sync2, r_sync3;
  logic [CntW-1:0] r_tick;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_par_s;
  logic            r_stop_s;
  logic [1:0]      r_ptype;
  logic [7:0]      r_raw;
  logic            r_parity_bit;
  logic            r_start_bit;
  logic            r_stop_bit;
  logic            r_flag;
  logic            r_busy;

  logic w_rx;
  logic w_fall;
  logic w_par_en;

  assign w_rx     = r_sync2;
  assign w_fall   = r_sync3 & ~r_sync2;
  assign w_par_en = (r_ptype == 2'b01) || (r_ptype == 2'b10);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_tick       <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_s      <= 1'b1;
      r_stop_s     <= 1'b1;
      r_ptype      <= 2'b00;
      r_raw        <= 8'h00;
      r_parity_bit <= 1'b1;
      r_start_bit  <= 1'b0;
      r_stop_bit   <= 1'b1;
      r_flag       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_flag <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_fall) begin
            r_state   <= StStart;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_ptype   <= bus.parity_type;
            r_busy    <= 1'b1;
          end
        end
        StStart: begin
          if (bus.baud_tick) begin
            if (r_tick == HalfM1) begin
              r_tick <= '0;
              if (!w_rx) begin
                r_state <= StData;
              end else begin
                // Glitch shorter than half a bit: drop it silently.
                r_state <= StIdle;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick <= r_tick + CntW'(1);
            end
          end
        end
        StData: begin
          if (bus.baud_tick) begin
            if (r_tick == LastTick) begin
              r_tick    <= '0;
              r_shift   <= {w_rx, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_state <= w_par_en ? StParity : StStop;
              end
            end else begin
              r_tick <= r_tick + CntW'(1);
            end
          end
        end
        StParity: begin
          if (bus.baud_tick) begin
            if (r_tick == LastTick) begin
              r_tick  <= '0;
              r_par_s <= w_rx;
              r_state <= StStop;
            end else begin
              r_tick <= r_tick + CntW'(1);
            end
          end
        end
        StStop: begin
          if (bus.baud_tick) begin
            if (r_tick == LastTick) begin
              r_tick   <= '0;
              r_stop_s <= w_rx;
              r_state  <= StDone;
            end else begin
              r_tick <= r_tick + CntW'(1);
            end
          end
        end
        StDone: begin
          r_raw        <= r_shift;
          r_parity_bit <= w_par_en ? r_par_s : 1'b1;
          r_start_bit  <= 1'b0;
          r_stop_bit   <= r_stop_s;
          r_flag       <= 1'b1;
          // An edge landing in this cycle starts the next frame directly.
          if (w_fall) begin
            r_state   <= StStart;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_ptype   <= bus.parity_type;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.raw_data      = r_raw;
  assign bus.parity_bit    = r_parity_bit;
  assign bus.start_bit     = r_start_bit;
  assign bus.stop_bit      = r_stop_bit;
  assign bus.recieved_flag = r_flag;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: 16x oversampling, one baud_tick every 4 clks.
module tb_rx_deframer;

  localparam int BIT = 64;  // clks per bit period (16 ticks x 4 clks)

  logic clk;
  logic reset_n;
  rx_deframer_if bus ();

  rx_deframer #(.OVERSAMPLE(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int flag_cnt = 0;
  int flag_cyc = 0;
  int start_cyc = 0;
  int tick_div = 0;
  logic [7:0] rec_raw [0:15];
  logic       rec_par [0:15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = tick_div + 1;
      bus.baud_tick = ((tick_div % 4) == 0);
    end
  end

  always @(negedge clk) begin
    if (bus.recieved_flag === 1'b1) begin
      rec_raw[flag_cnt[3:0]] = bus.raw_data;
      rec_par[flag_cnt[3:0]] = bus.parity_bit;
      flag_cnt = flag_cnt + 1;
      flag_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rx_in = b;
    wait_clks(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                            input logic sb, input bit flip);
    bus.parity_type = pt;
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == 3 && flip) bus.parity_type = 2'b00;
    end
    if (pt == 2'b01 || pt == 2'b10) send_bit(pb);
    send_bit(sb);
  endtask

  initial begin
    bus.rx_in = 1'b1;
    bus.parity_type = 2'b00;
    reset_n = 1'b0;
    wait_clks(5);
    chk("rst_raw", 32'(bus.raw_data), 32'h00);
    chk("rst_par", 32'(bus.parity_bit), 32'h1);
    chk("rst_start", 32'(bus.start_bit), 32'h0);
    chk("rst_stop", 32'(bus.stop_bit), 32'h1);
    chk("rst_flag", 32'(bus.recieved_flag), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    reset_n = 1'b1;
    wait_clks(10);

    // Even parity 0xA5
    send_frame(8'hA5, 2'b10, 1'b0, 1'b1, 1'b0);
    wait_clks(16);
    chk("a5_flags", 32'(flag_cnt), 32'd1);
    chk("a5_raw", 32'(bus.raw_data), 32'hA5);
    chk("a5_par", 32'(bus.parity_bit), 32'h0);
    chk("a5_start", 32'(bus.start_bit), 32'h0);
    chk("a5_stop", 32'(bus.stop_bit), 32'h1);
    chk("a5_busy", 32'(bus.busy), 32'h0);

    // No parity 0x3C, with latency window
    wait_clks(BIT);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b0);
    wait_clks(16);
    chk("3c_flags", 32'(flag_cnt), 32'd2);
    chk("3c_raw", 32'(bus.raw_data), 32'h3C);
    chk("3c_par", 32'(bus.parity_bit), 32'h1);
    chk("3c_latency", 32'((flag_cyc - start_cyc) >= 9 * BIT && (flag_cyc - start_cyc) <= 10 * BIT + 8),
        32'h1);

    // False start: low for 3 ticks
    wait_clks(BIT);
    bus.rx_in = 1'b0;
    wait_clks(12);
    bus.rx_in = 1'b1;
    wait_clks(2 * BIT);
    chk("fs_flags", 32'(flag_cnt), 32'd2);
    chk("fs_raw", 32'(bus.raw_data), 32'h3C);
    chk("fs_busy", 32'(bus.busy), 32'h0);

    // Odd parity 0x01, stop bit 0, line then held low
    send_frame(8'h01, 2'b01, 1'b0, 1'b0, 1'b0);
    wait_clks(16);
    chk("sb0_flags", 32'(flag_cnt), 32'd3);
    chk("sb0_raw", 32'(bus.raw_data), 32'h01);
    chk("sb0_par", 32'(bus.parity_bit), 32'h0);
    chk("sb0_stop", 32'(bus.stop_bit), 32'h0);
    wait_clks(3 * BIT);
    chk("sb0_noframe", 32'(flag_cnt), 32'd3);
    chk("sb0_busy", 32'(bus.busy), 32'h0);
    bus.rx_in = 1'b1;
    wait_clks(BIT);

    // Reset during bit 4 of 0xFF
    bus.parity_type = 2'b00;
    bus.rx_in = 1'b0;
    wait_clks(BIT);
    bus.rx_in = 1'b1;
    wait_clks(4 * BIT + 32);
    reset_n = 1'b0;
    wait_clks(3);
    chk("mr_raw", 32'(bus.raw_data), 32'h00);
    chk("mr_par", 32'(bus.parity_bit), 32'h1);
    chk("mr_start", 32'(bus.start_bit), 32'h0);
    chk("mr_stop", 32'(bus.stop_bit), 32'h1);
    chk("mr_busy", 32'(bus.busy), 32'h0);
    chk("mr_flag", 32'(bus.recieved_flag), 32'h0);
    reset_n = 1'b1;
    wait_clks(8 * BIT);
    chk("mr_noflag", 32'(flag_cnt), 32'd3);
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, 1'b0);
    wait_clks(16);
    chk("55_flags", 32'(flag_cnt), 32'd4);
    chk("55_raw", 32'(bus.raw_data), 32'h55);
    chk("55_par", 32'(bus.parity_bit), 32'h1);

    // Back-to-back odd parity 0x12, 0x34; parity_type dropped mid second frame
    wait_clks(BIT);
    send_frame(8'h12, 2'b01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h34, 2'b01, 1'b0, 1'b1, 1'b1);
    wait_clks(16);
    chk("b2b_flags", 32'(flag_cnt), 32'd6);
    chk("b2b_raw0", 32'(rec_raw[4]), 32'h12);
    chk("b2b_par0", 32'(rec_par[4]), 32'h1);
    chk("b2b_raw1", 32'(rec_raw[5]), 32'h34);
    chk("b2b_par1", 32'(rec_par[5]), 32'h0);
    chk("b2b_busy", 32'(bus.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_deframer.md
RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, giving baud_tick pulses per bit period (power of two, 8 or 16).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 baud_tick  input  1  oversampling enable, one clk wide, OVERSAMPLE per bit period.
REQ-005 rx_in  input  1  asynchronous serial line, idle high.
REQ-006 parity_type  input  2  01 odd, 10 even, 00/11 no parity.
REQ-007 raw_data  output  8  received data byte, LSB first on the line.
REQ-008 parity_bit  output  1  sampled parity bit; 1 when no parity.
REQ-009 start_bit  output  1  sampled start bit.
REQ-010 stop_bit  output  1  sampled stop bit.
REQ-011 recieved_flag  output  1  one-clk pulse: frame outputs valid and updated.
REQ-012 busy  output  1  high from start-edge detection until the DONE state is left.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchronizer; the edge detector SHALL use a third registered copy; all sampling SHALL use the synchronized value.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-015 IDLE: a synchronized 1->0 transition SHALL move to START, clear tick counter and bit index, and latch parity_type.
REQ-016 Tick counter SHALL be log2(OVERSAMPLE) bits, increment only on baud_tick, and wrap.
REQ-017 START: on baud_tick with counter == OVERSAMPLE/2-1, sample the line; 0 -> go to DATA with counter cleared; 1 -> false start, return to IDLE with no output change and no recieved_flag.
REQ-018 DATA/PARITY/STOP: each bit SHALL be sampled on baud_tick with counter == OVERSAMPLE-1, then the counter clears.
REQ-019 DATA SHALL shift in 8 bits LSB first; after bit index 7, go to PARITY if latched parity_type is 01 or 10, else go to STOP.
REQ-020 PARITY SHALL sample one bit, then go to STOP.
REQ-021 STOP SHALL sample one bit, then go to DONE regardless of its value; a 0 stop bit is reported, not suppressed.
REQ-022 DONE SHALL last exactly one clk: load raw_data, parity_bit (1 if no parity), start_bit (0), and stop_bit from internal shift registers; assert recieved_flag; return to IDLE.
REQ-023 raw_data, parity_bit, start_bit, and stop_bit SHALL change only in DONE or reset, and SHALL hold between frames.
REQ-024 recieved_flag latency SHALL be 1 clk after the stop-bit sample.
REQ-025 parity_type changes during a frame SHALL NOT affect that frame.
REQ-026 The block SHALL NOT compute or check parity or framing.
REQ-027 After DONE with line low (stop bit 0), a new frame SHALL NOT start until a fresh 1->0 transition.
REQ-028 A start edge SHALL be accepted in the clk immediately after DONE, so back-to-back frames lose nothing.
REQ-029 baud_tick with no state work pending SHALL have no effect in IDLE.

Reset
REQ-030 While reset_n is low: state IDLE, counters 0, synchronizer flops 1, raw_data 8'h00, parity_bit 1, start_bit 0, stop_bit 1, recieved_flag 0, busy 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no recieved_flag; after release, the block SHALL wait for a new 1->0 edge.

Verification
REQ-032 Even parity, byte 0xA5, parity 0, stop 1, 16x ticks -> one recieved_flag pulse; raw_data=8'hA5, parity_bit=0, start_bit=0, stop_bit=1; busy low afterwards.
REQ-033 No parity (00), byte 0x3C -> recieved_flag 10 bit periods (+ sync latency) after the start edge; raw_data=8'h3C, parity_bit=1.
REQ-034 rx_in low for 3 baud_ticks, then high -> return to IDLE; no recieved_flag; outputs unchanged.
REQ-035 Odd parity, byte 0x01, stop bit driven 0 -> recieved_flag pulses, stop_bit=0, parity_bit=0 as sent; no new frame until line rises and falls again.
REQ-036 Reset asserted during bit 4 of byte 0xFF -> all outputs at reset values, no flag; a following 0x55 frame is received correctly.
REQ-037 Two back-to-back frames 0x12, 0x34 (odd parity), no idle gap -> two recieved_flag pulses with raw_data 8'h12 then 8'h34.
